// File: rtl/matrix_input_assembler.sv
// Serial matrix assembler: takes row, column, then row-major elements and commits a flat matrix to a rotating slot.
// Optional INPUT_RANGE_CHECK_EN rejects data elements greater than ELEM_MAX.
module matrix_input_assembler #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_SIZE   = 5,
    parameter int MATRIX_NUM = 8,
    parameter int ELEM_MAX   = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    in_ready,
    output logic                    wr_en,
    output logic [2:0]              target_idx,
    output logic [2:0]              write_row,
    output logic [2:0]              write_col,
    output logic [25*DATA_WIDTH-1:0] data_flat,
    output logic                    busy,
    output logic                    err,
    output logic [4:0]              elem_cnt,
    output logic [2:0]              fsm_state
);

    // Handshake: a word transfers on a rising edge where in_valid and in_ready are both high;
    // in_ready depends only on state, and abort wins over a transfer in the same cycle.
    typedef enum logic [2:0] {IDLE, GET_ROW, GET_COL, GET_DATA, COMMIT} state_t;

    localparam logic [DATA_WIDTH-1:0] SIZE_LIMIT = DATA_WIDTH'(MAX_SIZE);
    localparam logic [DATA_WIDTH-1:0] ELEM_LIMIT = DATA_WIDTH'(ELEM_MAX);

    state_t     state, next_state;
    logic       size_ok, elem_ok;
    logic [5:0] product, cnt_inc;
    logic       clear, load_row, load_col, store_elem, reject, bump_idx;

    assign size_ok = (in_data != '0) && (in_data <= SIZE_LIMIT);
`ifdef INPUT_RANGE_CHECK_EN
    assign elem_ok = (in_data <= ELEM_LIMIT);
`else
    assign elem_ok = 1'b1;
`endif

    // 6-bit product so 5x5 = 25 does not wrap.
    assign product   = {3'b000, write_row} * {3'b000, write_col};
    assign cnt_inc   = {1'b0, elem_cnt} + 6'd1;
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        wr_en      = 1'b0;
        clear      = 1'b0;
        load_row   = 1'b0;
        load_col   = 1'b0;
        store_elem = 1'b0;
        reject     = 1'b0;
        bump_idx   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    clear      = 1'b1;
                    next_state = GET_ROW;
                end
            end
            GET_ROW: begin
                in_ready = 1'b1;
                if (abort) next_state = IDLE;
                else if (in_valid) begin
                    if (size_ok) begin
                        load_row   = 1'b1;
                        next_state = GET_COL;
                    end else begin
                        reject     = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            GET_COL: begin
                in_ready = 1'b1;
                if (abort) next_state = IDLE;
                else if (in_valid) begin
                    if (size_ok) begin
                        load_col   = 1'b1;
                        next_state = GET_DATA;
                    end else begin
                        reject     = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            GET_DATA: begin
                in_ready = 1'b1;
                if (abort) next_state = IDLE;
                else if (in_valid) begin
                    if (elem_ok) begin
                        store_elem = 1'b1;
                        if (cnt_inc == product) next_state = COMMIT;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            COMMIT: begin
                wr_en      = 1'b1;
                bump_idx   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_idx <= '0;
            write_row  <= '0;
            write_col  <= '0;
            data_flat  <= '0;
            elem_cnt   <= '0;
            err        <= 1'b0;
        end else begin
            err <= reject;
            if (clear) begin
                data_flat <= '0;
                elem_cnt  <= '0;
            end
            if (load_row) write_row <= in_data[2:0];
            if (load_col) write_col <= in_data[2:0];
            if (store_elem) begin
                data_flat[int'(elem_cnt)*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                elem_cnt <= elem_cnt + 5'd1;
            end
            if (bump_idx) begin
                if (target_idx == 3'(MATRIX_NUM - 1)) target_idx <= '0;
                else                                  target_idx <= target_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_matrix_input_assembler.sv
// Directed bench for matrix_input_assembler: reset, 2x3 commit, illegal sizes, abort, reset mid-matrix,
// slot wrap and the element range check (behaviour follows INPUT_RANGE_CHECK_EN).
module tb_matrix_input_assembler;

    localparam int DW = 8;
    localparam logic [2:0] S_IDLE = 3'd0, S_ROW = 3'd1, S_COL = 3'd2, S_DATA = 3'd3, S_COMMIT = 3'd4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            in_valid = 1'b0;
    logic [DW-1:0]   in_data = '0;
    logic            in_ready, wr_en, busy, err;
    logic [2:0]      target_idx, write_row, write_col, fsm_state;
    logic [25*DW-1:0] data_flat;
    logic [4:0]      elem_cnt;

    int tests = 0;
    int failures = 0;
    int wr_count = 0;
    int err_count = 0;
    logic [2:0] exp_q[$];
    logic [25*DW-1:0] exp_data;
    int wr_snap, err_snap;

    matrix_input_assembler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wr_en(wr_en), .target_idx(target_idx), .write_row(write_row),
        .write_col(write_col), .data_flat(data_flat), .busy(busy),
        .err(err), .elem_cnt(elem_cnt), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every commit pops the slot it should land in.
    always @(negedge clk) begin
        if (wr_en) begin
            wr_count++;
            if (exp_q.size() == 0) check("unexpected_wr_en", wr_en, 1'b0);
            else                   check("commit_slot", target_idx, exp_q.pop_front());
        end
        if (err) err_count++;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] v);
        in_valid = 1'b1;
        in_data  = v;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, fsm_state, S_IDLE);
        check({tag, "_target"}, target_idx, 3'd0);
        check({tag, "_row"}, write_row, 3'd0);
        check({tag, "_col"}, write_col, 3'd0);
        check({tag, "_data"}, data_flat, '0);
        check({tag, "_cnt"}, elem_cnt, 5'd0);
        check({tag, "_wr_en"}, wr_en, 1'b0);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    // 1x1 matrix; returns in the first IDLE cycle after COMMIT.
    task automatic mat1x1(input logic [DW-1:0] v);
        do_start();
        send(8'd1);
        send(8'd1);
        send(v);
        check("m1_wr_en", wr_en, 1'b1);
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        rst_n = 1'b1;
        cycle();

        // 2x3 matrix
        exp_q.push_back(3'd0);
        do_start();
        check("start_state", fsm_state, S_ROW);
        check("start_ready", in_ready, 1'b1);
        check("start_busy", busy, 1'b1);
        send(8'd2);
        send(8'd3);
        check("col_state", fsm_state, S_DATA);
        for (int k = 1; k <= 5; k++) send(DW'(k));
        check("pre_last_wr", wr_en, 1'b0);
        send(8'd6);
        exp_data = '0;
        for (int k = 0; k < 6; k++) exp_data[k*DW +: DW] = DW'(k + 1);
        check("m23_wr_en", wr_en, 1'b1);
        check("m23_target", target_idx, 3'd0);
        check("m23_row", write_row, 3'd2);
        check("m23_col", write_col, 3'd3);
        check("m23_data", data_flat, exp_data);
        check("m23_ready_commit", in_ready, 1'b0);
        cycle();
        check("m23_wr_drop", wr_en, 1'b0);
        check("m23_idle", fsm_state, S_IDLE);
        check("m23_target_inc", target_idx, 3'd1);
        cycle();
        check("m23_hold_data", data_flat, exp_data);
        check("m23_hold_row", write_row, 3'd2);

        // Illegal row 6, then illegal column 0
        wr_snap = wr_count;
        err_snap = err_count;
        do_start();
        send(8'd6);
        check("bad_row_err", err, 1'b1);
        check("bad_row_state", fsm_state, S_IDLE);
        cycle();
        check("bad_row_err_drop", err, 1'b0);
        do_start();
        send(8'd1);
        send(8'd0);
        check("bad_col_err", err, 1'b1);
        check("bad_col_state", fsm_state, S_IDLE);
        cycle();
        check("bad_size_err_count", err_count - err_snap, 2);
        check("bad_size_no_wr", wr_count - wr_snap, 0);
        check("bad_size_target", target_idx, 3'd1);

        // Abort after three elements of 3x3, with in_valid; start mid-matrix ignored
        wr_snap = wr_count;
        do_start();
        send(8'd3);
        send(8'd3);
        send(8'd1);
        send(8'd2);
        start = 1'b1;
        send(8'd3);
        start = 1'b0;
        check("start_ignored_cnt", elem_cnt, 5'd3);
        check("start_ignored_state", fsm_state, S_DATA);
        abort = 1'b1;
        send(8'd4);
        abort = 1'b0;
        check("abort_state", fsm_state, S_IDLE);
        check("abort_cnt", elem_cnt, 5'd3);
        check("abort_target", target_idx, 3'd1);
        check("abort_no_wr", wr_count - wr_snap, 0);
        exp_q.push_back(3'd1);
        mat1x1(8'd7);
        check("after_abort_data", data_flat, 200'h7);
        check("after_abort_target", target_idx, 3'd2);

        // Abort during COMMIT is ignored
        exp_q.push_back(3'd2);
        wr_snap = wr_count;
        do_start();
        send(8'd1);
        send(8'd1);
        send(8'd3);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check("commit_abort_wr", wr_count - wr_snap, 1);
        check("commit_abort_target", target_idx, 3'd3);

        // Reset in GET_DATA of a 5x5, then a full 5x5
        wr_snap = wr_count;
        do_start();
        send(8'd5);
        send(8'd5);
        for (int k = 0; k < 10; k++) send(DW'((k % 9) + 1));
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("mid_rst");
        check("mid_rst_no_wr", wr_count - wr_snap, 0);
        rst_n = 1'b1;
        cycle();
        exp_q.push_back(3'd0);
        do_start();
        send(8'd5);
        send(8'd5);
        exp_data = '0;
        for (int k = 0; k < 25; k++) begin
            exp_data[k*DW +: DW] = DW'((k % 9) + 1);
            send(DW'((k % 9) + 1));
        end
        check("m55_wr_en", wr_en, 1'b1);
        check("m55_target", target_idx, 3'd0);
        check("m55_row", write_row, 3'd5);
        check("m55_col", write_col, 3'd5);
        check("m55_cnt", elem_cnt, 5'd25);
        check("m55_data", data_flat, exp_data);
        cycle();

        // Slot wrap: nine back-to-back 1x1 matrices from reset
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        wr_snap = wr_count;
        for (int i = 0; i < 9; i++) exp_q.push_back(3'(i % 8));
        for (int i = 0; i < 9; i++) mat1x1(DW'(i + 1));
        check("wrap_wr_count", wr_count - wr_snap, 9);
        check("wrap_target", target_idx, 3'd1);

        // Element range: 1x2 fed 5, 12, 7 (second value only accepted without range checking)
        err_snap = err_count;
        exp_q.push_back(3'd1);
        do_start();
        send(8'd1);
        send(8'd2);
        send(8'd5);
        send(8'd12);
`ifdef INPUT_RANGE_CHECK_EN
        check("range_err", err, 1'b1);
        check("range_cnt", elem_cnt, 5'd1);
        check("range_state", fsm_state, S_DATA);
        send(8'd7);
        check("range_wr_en", wr_en, 1'b1);
        check("range_data", data_flat, 200'h0705);
`else
        check("norange_wr_en", wr_en, 1'b1);
        check("norange_data", data_flat, 200'h0c05);
`endif
        cycle();
`ifdef INPUT_RANGE_CHECK_EN
        check("range_err_count", err_count - err_snap, 1);
`else
        check("norange_err_count", err_count - err_snap, 0);
`endif
        check("range_target", target_idx, 3'd2);

        repeat (2) cycle();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/matrix_input_assembler.md
MATRIX_INPUT_ASSEMBLER -- requirements
Module: matrix_input_assembler

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, meaning element width in bits.
REQ-002 The module SHALL have parameter MAX_SIZE, default 5, meaning maximum row or column count.
REQ-003 The module SHALL have parameter MATRIX_NUM, default 8, meaning the number of storage slots that target_idx rotates through.
REQ-004 The module SHALL have parameter ELEM_MAX, default 9, meaning the largest legal element value when range checking is compiled in.
REQ-005 Port clk, input, 1 bit: rising-edge clock.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port start, input, 1 bit: single-cycle request to begin a new matrix.
REQ-008 Port abort, input, 1 bit: discard the matrix in progress.
REQ-009 Port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-010 Port in_data, input, DATA_WIDTH bits: serial stream of row, then column, then elements in row-major order.
REQ-011 Port in_ready, output, 1 bit: the module accepts in_data this cycle.
REQ-012 Port wr_en, output, 1 bit: single-cycle commit pulse to the downstream storage.
REQ-013 Port target_idx, output, 3 bits: storage slot for the commit.
REQ-014 Port write_row, output, 3 bits: committed row count; port write_col, output, 3 bits: committed column count.
REQ-015 Port data_flat, output, 25*DATA_WIDTH bits: element k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-016 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-017 Port err, output, 1 bit: single-cycle pulse on rejected input.
REQ-018 Port elem_cnt, output, 5 bits: number of elements accepted so far.

Function
REQ-019 The state machine SHALL have the states IDLE, GET_ROW, GET_COL, GET_DATA and COMMIT.
REQ-020 A transfer SHALL occur only in a cycle where in_valid and in_ready are both 1.
REQ-021 in_ready SHALL be 1 only in GET_ROW, GET_COL and GET_DATA.
REQ-022 In IDLE, start SHALL clear data_flat to 0 and elem_cnt to 0, and move to GET_ROW on the next cycle.
REQ-023 start SHALL be ignored in every state other than IDLE.
REQ-024 GET_ROW SHALL accept a value of 1..MAX_SIZE as write_row and move to GET_COL.
REQ-025 GET_ROW SHALL reject any other value by pulsing err and returning to IDLE.
REQ-026 GET_COL SHALL behave as GET_ROW: a legal value is stored as write_col and the state moves to GET_DATA; an illegal value pulses err and returns to IDLE.
REQ-027 GET_DATA SHALL store each transferred element at index elem_cnt and then increment elem_cnt.
REQ-028 When the element transferred is number write_row*write_col (elem_cnt reaches the product), the state SHALL move to COMMIT.
REQ-029 The product write_row*write_col SHALL be computed in at least 5 bits, so that 5x5 yields 25 with no overflow.
REQ-030 In COMMIT, wr_en SHALL be 1 for exactly one cycle, with data_flat, write_row, write_col and target_idx stable.
REQ-031 Elements at index write_row*write_col or above SHALL read as 0.
REQ-032 On the cycle after COMMIT, the state SHALL be IDLE and target_idx SHALL increment, wrapping from MATRIX_NUM-1 to 0.
REQ-033 abort in GET_ROW, GET_COL or GET_DATA SHALL return the state to IDLE on the next cycle, with no wr_en and target_idx unchanged.
REQ-034 abort SHALL take priority over a transfer in the same cycle.
REQ-035 abort in COMMIT SHALL be ignored, so the commit completes.
REQ-036 Latency SHALL be one cycle from the final element transfer to wr_en.
REQ-037 A start arriving in the first IDLE cycle after COMMIT SHALL be accepted.
REQ-038 data_flat, write_row and write_col SHALL hold their values in IDLE until the next start.

Reset
REQ-039 While rst_n is 0, the state SHALL be IDLE and target_idx, write_row, write_col, data_flat and elem_cnt SHALL be 0.
REQ-040 While rst_n is 0, wr_en, in_ready, busy and err SHALL be 0.
REQ-041 Reset asserted mid-matrix SHALL discard the partial matrix and produce no wr_en.

Configuration
REQ-042 With macro INPUT_RANGE_CHECK_EN defined, a GET_DATA element greater than ELEM_MAX SHALL be rejected: err pulses for one cycle, the element is not stored, elem_cnt is unchanged, and the state stays in GET_DATA.
REQ-043 Without INPUT_RANGE_CHECK_EN, every GET_DATA element SHALL be accepted unchanged, and err SHALL pulse only on an illegal row or column.

Verification
REQ-044 Scenario, 2x3 matrix: start, then 2, 3, 1, 2, 3, 4, 5, 6 -> wr_en pulses 1 cycle after the final element; target_idx=0; row=2, col=3; elements 0..5 = 1..6; elements 6..24 = 0.
REQ-045 Scenario, slot wrap: nine back-to-back 1x1 matrices -> target_idx sequence 0,1,...,7,0.
REQ-046 Scenario, illegal size: start, then row 6 -> err pulses once, state returns to IDLE, no wr_en.
REQ-047 Scenario, abort: abort after 3 elements of a 3x3 matrix, asserted together with in_valid -> IDLE next cycle, no wr_en, target_idx unchanged; the following matrix commits to the same slot.
REQ-048 Scenario, range check (INPUT_RANGE_CHECK_EN defined): 1x2 matrix fed 5, 12, 7 -> err pulses on 12; committed elements = 5, 7.
REQ-049 Scenario, reset mid-matrix: rst_n asserted during GET_DATA of a 5x5 matrix -> all outputs 0; after release, a new 5x5 matrix commits all 25 elements to target_idx=0.
